// File: rtl/instr_fetch.sv
// instr_fetch: single-stage fetch that hands one instruction per cycle to decode over valid/ready.
// Define FETCH_HALT_EN to make EBREAK stop fetching until the next redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] Dir,
    input  logic [31:0] Inst,
    input  logic        redir_en,
    input  logic [31:0] redir_pc,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`ifdef FETCH_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif
    state_t      state;
    logic [31:0] pc;
    logic        halt_q;
    logic        is_brk;
    logic        load;
    assign Dir    = {2'b00, pc[31:2]};
    assign is_brk = HALT_EN && (Inst == 32'h0010_0073);
    assign load   = (state == RUN) && (!valid_out || ready_in);
    assign halted = HALT_EN & halt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            valid_out   <= 1'b0;
            inst_out    <= 32'h0;
            pc_out      <= 32'h0;
            fetch_count <= 32'h0;
            halt_q      <= 1'b0;
        end else begin
            if (valid_out && ready_in) fetch_count <= fetch_count + 32'd1;
            if (redir_en) begin
                state     <= RUN;
                pc        <= {redir_pc[31:2], 2'b00};
                valid_out <= 1'b0;
                halt_q    <= 1'b0;
            end else if (load) begin
                inst_out  <= Inst;
                pc_out    <= pc;
                valid_out <= 1'b1;
                pc        <= is_brk ? pc : pc + 32'd4;
                if (is_brk) begin
                    halt_q <= 1'b1;
                    state  <= HALT;
                end
            end else if (state == BOOT) begin
                state <= RUN;
            end else if (state == HALT && ready_in) begin
                // the EBREAK itself still completes its handshake before fetch goes quiet
                valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: vector table, halt/EBREAK sequence and randomized stream checks for instr_fetch.
module tb_instr_fetch;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n = 1'b0, redir_en = 1'b0, ready_in = 1'b0, brk_on = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic [31:0] dir1, inst1, io1, po1, fc1, dir2, inst2, io2, po2, fc2;
    logic        vo1, h1, vo2, h2;
    int errors = 0, checks = 0;

    // memory word k holds k; word 3 optionally holds EBREAK
    assign inst1 = (brk_on && dir1 == 32'd3) ? EBREAK : dir1;
    assign inst2 = dir2;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .Dir(dir1), .Inst(inst1), .redir_en(redir_en),
        .redir_pc(redir_pc), .ready_in(ready_in), .valid_out(vo1), .inst_out(io1),
        .pc_out(po1), .halted(h1), .fetch_count(fc1)
    );
    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .Dir(dir2), .Inst(inst2), .redir_en(redir_en),
        .redir_pc(redir_pc), .ready_in(ready_in), .valid_out(vo2), .inst_out(io2),
        .pc_out(po2), .halted(h2), .fetch_count(fc2)
    );

    typedef struct {
        logic        r, rd;
        logic [31:0] rp;
        logic        rdy, ev;
        logic [31:0] ei, ep, ed, ec, ep2;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        rst_n = r; redir_en = rd; redir_pc = rp; ready_in = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        pv, pinst_ok, rd, rdy;
        logic [31:0] pinst, ppc, rp, exp_pc, mcnt;
        logic        first;
        tbl[0]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  32'h0,  32'h1,  32'h0, 32'hFFFF_FFF8};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h1,  32'h4,  32'h2,  32'h1, 32'hFFFF_FFFC};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h2,  32'h8,  32'h3,  32'h2, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h3,  32'hC,  32'h4,  32'h3, 32'h4};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  32'h10, 32'h5,  32'h4, 32'h8};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h5,  32'h14, 32'h6,  32'h5, 32'hC};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h5,  32'h14, 32'h6,  32'h5, 32'hC};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h5,  32'h14, 32'h6,  32'h5, 32'hC};
        tbl[10] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h5,  32'h14, 32'h6,  32'h5, 32'hC};
        tbl[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h6,  32'h18, 32'h7,  32'h6, 32'h10};
        tbl[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h7,  32'h1C, 32'h8,  32'h7, 32'h14};
        tbl[13] = '{1'b1, 1'b1, 32'h22, 1'b1, 1'b0, 32'h7,  32'h1C, 32'h8,  32'h8, 32'h14};
        tbl[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  32'h20, 32'h9,  32'h8, 32'h20};
        tbl[15] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h8,  32'h20, 32'h9,  32'h8, 32'h20};
        tbl[16] = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0, 32'h0};
        tbl[17] = '{1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,  32'h10, 32'h0, 32'h0};
        tbl[18] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 32'h40, 32'h11, 32'h0, 32'h40};
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].r, tbl[i].rd, tbl[i].rp, tbl[i].rdy);
            chk($sformatf("v%0d_valid", i), {31'b0, vo1}, {31'b0, tbl[i].ev});
            chk($sformatf("v%0d_inst", i), io1, tbl[i].ei);
            chk($sformatf("v%0d_pc", i), po1, tbl[i].ep);
            chk($sformatf("v%0d_dir", i), dir1, tbl[i].ed);
            chk($sformatf("v%0d_count", i), fc1, tbl[i].ec);
            chk($sformatf("v%0d_halted", i), {31'b0, h1}, 32'h0);
            chk($sformatf("v%0d_wrap_pc", i), po2, tbl[i].ep2);
            if (!tbl[i].r) chk($sformatf("v%0d_wrap_dir", i), dir2, 32'h3FFF_FFFE);
        end

        // EBREAK at word 3
        brk_on = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("brk_inst", io1, EBREAK);
        chk("brk_pc", po1, 32'hC);
        chk("brk_valid", {31'b0, vo1}, 32'h1);
`ifdef FETCH_HALT_EN
        chk("brk_halted", {31'b0, h1}, 32'h1);
        chk("brk_dir", dir1, 32'h3);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("halt_drain_valid", {31'b0, vo1}, 32'h0);
        chk("halt_drain_count", fc1, 32'h4);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("halt_idle_valid", {31'b0, vo1}, 32'h0);
        chk("halt_idle_inst", io1, EBREAK);
        chk("halt_idle_dir", dir1, 32'h3);
        chk("halt_idle_halted", {31'b0, h1}, 32'h1);
        cyc(1'b1, 1'b1, 32'h0, 1'b1);
        chk("halt_redir_halted", {31'b0, h1}, 32'h0);
        chk("halt_redir_valid", {31'b0, vo1}, 32'h0);
        chk("halt_redir_dir", dir1, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("halt_restart_inst", io1, 32'h0);
        chk("halt_restart_pc", po1, 32'h0);
        chk("halt_restart_valid", {31'b0, vo1}, 32'h1);
`else
        chk("brk_halted", {31'b0, h1}, 32'h0);
        chk("brk_dir", dir1, 32'h4);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("brk_next_inst", io1, 32'h4);
        chk("brk_next_pc", po1, 32'h10);
        chk("brk_next_halted", {31'b0, h1}, 32'h0);
`endif
        brk_on = 1'b0;

        // random stream: every handshake must deliver the next sequential word since the last redirect
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        exp_pc = 32'h0;
        mcnt   = 32'h0;
        first  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            pv    = vo1;
            pinst = io1;
            ppc   = po1;
            rd    = ($urandom_range(0, 9) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
            rp    = $urandom_range(0, 65535);
            rst_n = 1'b1; redir_en = rd; redir_pc = rp; ready_in = rdy;
            @(posedge clk);
            #1;
            if (pv && rdy) begin
                pinst_ok = (pinst == {2'b00, ppc[31:2]});
                chk($sformatf("rnd%0d_pc", i), ppc, exp_pc);
                chk($sformatf("rnd%0d_inst_match", i), {31'b0, pinst_ok}, 32'h1);
                mcnt   = mcnt + 32'd1;
                exp_pc = exp_pc + 32'd4;
            end
            if (rd) begin
                exp_pc = {rp[31:2], 2'b00};
                chk($sformatf("rnd%0d_bubble", i), {31'b0, vo1}, 32'h0);
            end else if (pv && !rdy) begin
                chk($sformatf("rnd%0d_stall_pc", i), po1, ppc);
                chk($sformatf("rnd%0d_stall_inst", i), io1, pinst);
                chk($sformatf("rnd%0d_stall_valid", i), {31'b0, vo1}, 32'h1);
            end else if (!first) begin
                chk($sformatf("rnd%0d_tput", i), {31'b0, vo1}, 32'h1);
            end
            chk($sformatf("rnd%0d_count", i), fc1, mcnt);
            first = 1'b0;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port Dir  output  32  word index presented to instruction memory, equal to {2'b00, pc[31:2]}.
REQ-005 Port Inst  input  32  instruction word returned combinationally by memory for the current Dir.
REQ-006 Port redir_en  input  1  redirect request (branch/jump taken).
REQ-007 Port redir_pc  input  32  redirect target byte address.
REQ-008 Port ready_in  input  1  decode stage can accept an instruction this cycle.
REQ-009 Port valid_out  output  1  inst_out/pc_out hold a valid instruction.
REQ-010 Port inst_out  output  32  registered instruction to decode.
REQ-011 Port pc_out  output  32  byte address of inst_out.
REQ-012 Port halted  output  1  fetch stopped on EBREAK; constant 0 when FETCH_HALT_EN is undefined.
REQ-013 Port fetch_count  output  32  number of completed handshakes (valid_out & ready_in).

Function
REQ-014 The block SHALL implement states BOOT, RUN and HALT; HALT is reachable only when FETCH_HALT_EN is defined.
REQ-015 BOOT SHALL last exactly one cycle after reset release with valid_out=0, then transition unconditionally to RUN unless redir_en=1, in which case it SHALL still go to RUN with pc loaded from redir_pc.
REQ-016 In RUN, a load SHALL occur when (valid_out==0 or ready_in==1) and redir_en==0: inst_out<=Inst, pc_out<=pc, valid_out<=1, pc<=pc+4.
REQ-017 When valid_out==1 and ready_in==0 and redir_en==0, inst_out, pc_out, valid_out and pc SHALL hold (stall).
REQ-018 When valid_out==1, ready_in==0 and no load occurs, valid_out SHALL NOT drop except on redirect or reset.
REQ-019 redir_en==1 SHALL take priority in every state: pc<={redir_pc[31:2],2'b00}, valid_out<=0 next cycle, no load this cycle, state<=RUN.
REQ-020 Load latency: a word presented on Inst in cycle N SHALL appear on inst_out in cycle N+1.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) without error.
REQ-022 fetch_count SHALL increment by 1 in every cycle where valid_out==1 and ready_in==1, including a cycle with simultaneous redir_en, and SHALL wrap modulo 2^32.
REQ-023 The handshake in REQ-022 and a new load in REQ-016 SHALL occur in the same cycle without a bubble (full throughput of one instruction per cycle).

Reset
REQ-024 While rst_n==0 at a rising edge: state<=BOOT, pc<=RESET_PC, valid_out<=0, inst_out<=0, pc_out<=0, fetch_count<=0, halted<=0.
REQ-025 Reset asserted mid-stall, mid-halt or coincident with redir_en SHALL override all other inputs.
REQ-026 Dir SHALL equal {2'b00, RESET_PC[31:2]} in the cycle following reset.

Configuration
REQ-027 Macro FETCH_HALT_EN: when defined, a load whose Inst==32'h0010_0073 (EBREAK) SHALL still deliver the instruction, leave pc unchanged, set halted<=1 and enter HALT.
REQ-028 In HALT, no new load SHALL occur; an undelivered valid_out SHALL still complete its handshake; redir_en SHALL clear halted and return to RUN per REQ-019.
REQ-029 When FETCH_HALT_EN is undefined, EBREAK SHALL be fetched as an ordinary instruction and halted SHALL be tied to 0.

Verification
REQ-030 Reset with RESET_PC=0, ready_in=1, memory word k = k -> after BOOT, inst_out=0,1,2,3 on consecutive cycles with pc_out=0,4,8,12; fetch_count=4 after four handshakes.
REQ-031 ready_in=0 for 3 cycles while valid_out=1, inst_out=5 -> inst_out, pc_out=20, Dir=6 held; fetch_count unchanged; resumes with inst_out=6 one cycle after ready_in=1.
REQ-032 redir_en=1, redir_pc=32'h0000_0022 during a handshake -> fetch_count increments, valid_out=0 next cycle, Dir=8, next inst_out from word 8 with pc_out=32'h20.
REQ-033 RESET_PC=32'hFFFF_FFF8, ready_in=1 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 FETCH_HALT_EN defined, word 3 = 32'h0010_0073 -> inst_out=EBREAK delivered with pc_out=12, halted=1, no further loads; redir_en with redir_pc=0 -> halted=0, fetch restarts at word 0.
REQ-035 rst_n=0 for one cycle during a stall with fetch_count=7 -> next cycle valid_out=0, fetch_count=0, halted=0, Dir={2'b00, RESET_PC[31:2]}.
